// File: rtl/tqvp_vgacon_term_ctrl.sv
// tqvp_vgacon_term_ctrl: terminal byte interpreter with hardware cursor, scroll and clear sequencing
module tqvp_vgacon_term_ctrl #(
  parameter int NUM_ROWS = 3,
  parameter int NUM_COLS = 10,
  parameter int ADDR_W = $clog2(NUM_ROWS*NUM_COLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [7:0]        cmd_data,
  output logic              cmd_ready,
  input  logic [1:0]        color,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [8:0]        buf_wdata,
  output logic [ADDR_W-1:0] buf_raddr,
  input  logic [8:0]        buf_rdata,
  output logic [1:0]        cursor_row,
  output logic [3:0]        cursor_col,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, SCROLL_COPY, SCROLL_CLEAR, CLEAR} state_t;
  localparam logic [8:0]        BLANK     = 9'h020;
  localparam logic [3:0]        COL_LAST  = 4'(NUM_COLS-1);
  localparam logic [1:0]        ROW_LAST  = 2'(NUM_ROWS-1);
  localparam logic [ADDR_W-1:0] COLS      = ADDR_W'(NUM_COLS);
  localparam logic [ADDR_W-1:0] COPY_LAST = ADDR_W'((NUM_ROWS-1)*NUM_COLS-1);
  localparam logic [ADDR_W-1:0] CELL_LAST = ADDR_W'(NUM_ROWS*NUM_COLS-1);
  state_t state, state_n;
  logic [ADDR_W-1:0] p, p_n, waddr_n, cur_addr;
  logic [8:0] wdata_n;
  logic [1:0] row_n;
  logic [3:0] col_n;
  logic we_n, lf, printable;
  assign cmd_ready = state == IDLE;
  assign busy = ~cmd_ready;
  assign buf_raddr = (state == SCROLL_COPY) ? p + COLS : '0;
  assign cur_addr = ADDR_W'(cursor_row) * COLS + ADDR_W'(cursor_col);
  assign printable = cmd_data >= 8'h20 && cmd_data <= 8'h7e;
  always_comb begin
    state_n = state;
    p_n = p;
    row_n = cursor_row;
    col_n = cursor_col;
    we_n = 1'b0;
    waddr_n = buf_waddr;
    wdata_n = buf_wdata;
    lf = 1'b0;
    case (state)
      IDLE: if (cmd_valid) begin
        if (printable) begin
          we_n = 1'b1;
          waddr_n = cur_addr;
          wdata_n = {color, cmd_data[6:0]};
          if (cursor_col < COL_LAST) col_n = cursor_col + 4'd1;
          else lf = 1'b1;
        end else if (cmd_data == 8'h0a) lf = 1'b1;
        else if (cmd_data == 8'h0d) col_n = '0;
        else if (cmd_data == 8'h08 && cursor_col != '0) begin
          col_n = cursor_col - 4'd1;
          we_n = 1'b1;
          waddr_n = cur_addr - ADDR_W'(1);
          wdata_n = BLANK;
        end else if (cmd_data == 8'h0c) begin
          row_n = '0;
          col_n = '0;
          p_n = '0;
          state_n = CLEAR;
        end
        // A wrapping printable is already latched for the last cell; the copy lifts it a row.
        if (lf) begin
          col_n = '0;
          if (cursor_row < ROW_LAST) row_n = cursor_row + 2'd1;
          else begin
            p_n = '0;
            state_n = SCROLL_COPY;
          end
        end
      end
      SCROLL_COPY: begin
        we_n = 1'b1;
        waddr_n = p;
        wdata_n = buf_rdata;
        p_n = p + ADDR_W'(1);
        if (p == COPY_LAST) state_n = SCROLL_CLEAR;
      end
      default: begin
        we_n = 1'b1;
        waddr_n = p;
        wdata_n = BLANK;
        p_n = (p == CELL_LAST) ? '0 : p + ADDR_W'(1);
        if (p == CELL_LAST) state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      p <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      buf_we <= 1'b0;
      buf_waddr <= '0;
      buf_wdata <= '0;
    end else begin
      state <= state_n;
      p <= p_n;
      cursor_row <= row_n;
      cursor_col <= col_n;
      buf_we <= we_n;
      buf_waddr <= waddr_n;
      buf_wdata <= wdata_n;
    end
  end
endmodule
